// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts slave-busy cycles of the granted transaction and flags a hang.
// Ports: clk, resetn (async active-low); busy_i = a grant is active,
// valid_i = owner still requesting, s_ready_i = slave completion;
// expire_o = force-complete this cycle, err_o = sticky expiry flag.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic busy_i,
  input  logic valid_i,
  input  logic s_ready_i,
  output logic expire_o,
  output logic err_o
);
  logic [15:0] cnt_q;
  logic        err_q;
  // A slave answer on the expiry cycle wins, so expiry needs s_ready low.
  assign expire_o = busy_i && valid_i && !s_ready_i && cnt_q == 16'(TIMEOUT_CYCLES - 1);
  assign err_o    = err_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= !busy_i ? '0 : s_ready_i ? cnt_q : cnt_q + 16'd1;
      err_q <= err_q | expire_o;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one native memory port between two masters.
// Ports: clk, resetn (async active-low); m0_* CPU master, m1_* host master
// (valid/addr/wdata/wstrb in, ready/rdata out); s_* slave port; owner = registered
// grant (00 none, 01 m0, 10 m1); timeout_err = sticky watchdog flag.
// Build option: define MEM_ARB_TIMEOUT_EN to enable the hung-slave watchdog.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          owner,
  output logic                timeout_err
);
  state_e            state_q;
  logic              last_q;
  logic [1:0]        owner_q;
  logic              busy, own0, own1, mv, expire, done;
  logic [DATA_W-1:0] rsp;
  assign busy = state_q != IDLE;
  assign own0 = state_q == BUSY0;
  assign own1 = state_q == BUSY1;
  assign mv   = own0 ? m0_valid : own1 && m1_valid;
  // Completion needs the owner still requesting; a dropped valid ends the grant silently.
  assign done = mv && (s_ready || expire);
  assign rsp  = expire ? DATA_W'(ERR_DATA) : s_rdata;
  assign s_valid  = mv && !expire;
  assign s_addr   = own0 ? m0_addr  : own1 ? m1_addr  : '0;
  assign s_wdata  = own0 ? m0_wdata : own1 ? m1_wdata : '0;
  assign s_wstrb  = own0 ? m0_wstrb : own1 ? m1_wstrb : '0;
  assign m0_ready = done && own0;
  assign m1_ready = done && own1;
  assign m0_rdata = own0 ? rsp : '0;
  assign m1_rdata = own1 ? rsp : '0;
  assign owner    = owner_q;
`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk       (clk),
    .resetn    (resetn),
    .busy_i    (busy),
    .valid_i   (mv),
    .s_ready_i (s_ready),
    .expire_o  (expire),
    .err_o     (timeout_err)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = busy | (TIMEOUT_CYCLES == 0);
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // last_q = 1 means m1 was served last, so m0 wins a tie out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= OWN_NONE;
    end else if (state_q == IDLE) begin
      if (m0_valid && (!m1_valid || last_q)) begin
        state_q <= BUSY0;
        owner_q <= OWN_M0;
      end else if (m1_valid) begin
        state_q <= BUSY1;
        owner_q <= OWN_M1;
      end
    end else if (done || !mv) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      if (done) last_q <= own1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO = 64;
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn;
  logic m0_valid, m1_valid, m0_ready, m1_ready, s_valid, s_ready, timeout_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0] m0_wstrb, m1_wstrb, s_wstrb;
  logic [1:0] owner;
  int pass_cnt = 0;
  int total = 0;
  always #5 clk = ~clk;
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .owner(owner), .timeout_err(timeout_err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
  endtask
  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    step();
    step();
    resetn = 1;
  endtask
  task automatic test_reset();
    resetn = 0;
    idle_inputs();
    m0_valid = 1; m1_valid = 1; m0_addr = 32'h44; m1_addr = 32'h88;
    s_ready = 1; s_rdata = 32'hFFFF_FFFF;
    step();
    step();
    total++; if ({owner, s_valid, m0_ready, m1_ready, timeout_err} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {owner, s_valid, m0_ready, m1_ready, timeout_err}); else pass_cnt++;
    total++; if ({s_addr, s_wdata, s_wstrb} !== 68'h0) $display("FAIL reset_sbus: got %h want 0", {s_addr, s_wdata, s_wstrb}); else pass_cnt++;
    total++; if ({m0_rdata, m1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); else pass_cnt++;
    resetn = 1;
    idle_inputs();
  endtask
  task automatic test_single_read();
    do_reset();
    m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 0;
    s_ready = 1; s_rdata = 32'hAAAA_5555;
    #1;
    total++; if ({owner, s_valid, m0_ready, m1_ready, m0_rdata} !== 37'h0) $display("FAIL idle_ignore_ready: got %h want 0", {owner, s_valid, m0_ready, m1_ready, m0_rdata}); else pass_cnt++;
    s_ready = 0;
    step();
    total++; if ({owner, s_valid, s_addr, m0_ready} !== {2'b01, 1'b1, 32'h10, 1'b0}) $display("FAIL read_grant: got %h want %h", {owner, s_valid, s_addr, m0_ready}, {2'b01, 1'b1, 32'h10, 1'b0}); else pass_cnt++;
    step();
    step();
    s_ready = 1; s_rdata = 32'h1234_5678;
    #1;
    total++; if ({m0_ready, m0_rdata, m1_ready, owner} !== {1'b1, 32'h1234_5678, 1'b0, 2'b01}) $display("FAIL read_resp: got %h want %h", {m0_ready, m0_rdata, m1_ready, owner}, {1'b1, 32'h1234_5678, 1'b0, 2'b01}); else pass_cnt++;
    step();
    s_ready = 0; m0_valid = 0;
    #1;
    total++; if ({owner, m0_ready, m1_ready} !== 4'b0) $display("FAIL read_release: got %b want 0000", {owner, m0_ready, m1_ready}); else pass_cnt++;
  endtask
  task automatic test_simultaneous();
    do_reset();
    m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'h0BAD_0000;
    for (int i = 0; i < 4; i++) begin
      total++; if ({owner, m0_ready, m1_ready} !== 4'b0) $display("FAIL rr_idle%0d: got %b want 0000", i, {owner, m0_ready, m1_ready}); else pass_cnt++;
      step();
      total++; if ({owner, m0_ready, m1_ready} !== ((i % 2 == 0) ? 4'b0110 : 4'b1001)) $display("FAIL rr_grant%0d: got %b want %b", i, {owner, m0_ready, m1_ready}, (i % 2 == 0) ? 4'b0110 : 4'b1001); else pass_cnt++;
      step();
    end
    idle_inputs();
  endtask
  task automatic test_write_passthrough();
    do_reset();
    m0_addr = 32'h7777_0000; m0_wdata = 32'h1111_2222;
    m1_valid = 1; m1_addr = 32'h20; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;
    step();
    total++; if ({owner, s_valid, s_addr, s_wdata, s_wstrb} !== {2'b10, 1'b1, 32'h20, 32'hCAFE_F00D, 4'b0011}) $display("FAIL write_pass: got %h want %h", {owner, s_valid, s_addr, s_wdata, s_wstrb}, {2'b10, 1'b1, 32'h20, 32'hCAFE_F00D, 4'b0011}); else pass_cnt++;
    total++; if ({m0_ready, m1_ready} !== 2'b00) $display("FAIL write_wait: got %b want 00", {m0_ready, m1_ready}); else pass_cnt++;
    s_ready = 1;
    #1;
    total++; if ({m0_ready, m1_ready} !== 2'b01) $display("FAIL write_done: got %b want 01", {m0_ready, m1_ready}); else pass_cnt++;
    step();
    idle_inputs();
  endtask
  task automatic test_reset_mid();
    do_reset();
    m1_valid = 1;
    step();
    total++; if (owner !== 2'b10) $display("FAIL mid_busy1: got %b want 10", owner); else pass_cnt++;
    m0_valid = 1; s_ready = 0;
    #2 resetn = 0;
    s_ready = 1;
    #1;
    total++; if ({owner, s_valid, m0_ready, m1_ready} !== 5'b0) $display("FAIL mid_reset: got %b want 00000", {owner, s_valid, m0_ready, m1_ready}); else pass_cnt++;
    step();
    resetn = 1;
    step();
    total++; if ({owner, m0_ready} !== 3'b011) $display("FAIL mid_regrant: got %b want 011", {owner, m0_ready}); else pass_cnt++;
    idle_inputs();
    step();
  endtask
`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_valid = 1; m0_addr = 32'h40; s_ready = 0; s_rdata = 32'h0123_4567;
    step();
    for (int i = 1; i < 8; i++) begin
      total++; if ({m0_ready, s_valid} !== 2'b01) $display("FAIL to_wait%0d: got %b want 01", i, {m0_ready, s_valid}); else pass_cnt++;
      step();
    end
    total++; if ({m0_ready, m0_rdata, s_valid, m1_ready, timeout_err} !== {1'b1, 32'hDEAD_BEEF, 3'b000}) $display("FAIL to_expire: got %h want %h", {m0_ready, m0_rdata, s_valid, m1_ready, timeout_err}, {1'b1, 32'hDEAD_BEEF, 3'b000}); else pass_cnt++;
    step();
    m0_valid = 0;
    total++; if ({owner, timeout_err} !== 3'b001) $display("FAIL to_flag: got %b want 001", {owner, timeout_err}); else pass_cnt++;
    repeat (3) step();
    total++; if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_err); else pass_cnt++;
    do_reset();
    total++; if (timeout_err !== 1'b0) $display("FAIL to_clear: got %b want 0", timeout_err); else pass_cnt++;
    m0_valid = 1;
    step();
    repeat (7) step();
    s_ready = 1; s_rdata = 32'h55AA_1234;
    #1;
    total++; if ({m0_ready, m0_rdata, s_valid} !== {1'b1, 32'h55AA_1234, 1'b1}) $display("FAIL to_tie: got %h want %h", {m0_ready, m0_rdata, s_valid}, {1'b1, 32'h55AA_1234, 1'b1}); else pass_cnt++;
    step();
    idle_inputs();
    total++; if ({owner, timeout_err} !== 3'b000) $display("FAIL to_tie_flag: got %b want 000", {owner, timeout_err}); else pass_cnt++;
  endtask
`endif
  task automatic test_random();
    int cur = -1;
    int last = 1;
    int wd = 0;
    bit err = 0;
    bit r0 = 0;
    bit r1 = 0;
    bit mv, ex, e_r0, e_r1;
    logic [1:0] e_own;
    logic [67:0] e_s;
    logic [31:0] e_rd0, e_rd1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (r0 || !m0_valid) begin m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom_range(0, 15)); end
      if (r1 || !m1_valid) begin m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom_range(0, 15)); end
      m0_valid = r0 ? ($urandom_range(0, 9) < 7) : m0_valid ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 9) < 4);
      m1_valid = r1 ? ($urandom_range(0, 9) < 7) : m1_valid ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 9) < 4);
      s_ready = $urandom_range(0, 9) < 3;
      s_rdata = $urandom;
      #3;
      mv = (cur == 0) ? m0_valid : (cur == 1) ? m1_valid : 1'b0;
      ex = TO_EN && mv && !s_ready && wd == TO - 1;
      e_r0 = cur == 0 && mv && (s_ready || ex);
      e_r1 = cur == 1 && mv && (s_ready || ex);
      e_rd0 = (cur != 0) ? 32'h0 : ex ? 32'hDEAD_BEEF : s_rdata;
      e_rd1 = (cur != 1) ? 32'h0 : ex ? 32'hDEAD_BEEF : s_rdata;
      e_own = (cur < 0) ? 2'b00 : (cur == 0) ? 2'b01 : 2'b10;
      e_s = (cur < 0) ? 68'h0 : (cur == 0) ? {m0_addr, m0_wdata, m0_wstrb} : {m1_addr, m1_wdata, m1_wstrb};
      total++; if ({s_valid, s_addr, s_wdata, s_wstrb} !== {mv && !ex, e_s}) $display("FAIL rnd_sbus@%0d: got %h want %h", n, {s_valid, s_addr, s_wdata, s_wstrb}, {mv && !ex, e_s}); else pass_cnt++;
      total++; if ({m0_ready, m0_rdata} !== {e_r0, e_rd0}) $display("FAIL rnd_m0@%0d: got %h want %h", n, {m0_ready, m0_rdata}, {e_r0, e_rd0}); else pass_cnt++;
      total++; if ({m1_ready, m1_rdata} !== {e_r1, e_rd1}) $display("FAIL rnd_m1@%0d: got %h want %h", n, {m1_ready, m1_rdata}, {e_r1, e_rd1}); else pass_cnt++;
      total++; if ({owner, timeout_err} !== {e_own, err}) $display("FAIL rnd_owner@%0d: got %b want %b", n, {owner, timeout_err}, {e_own, err}); else pass_cnt++;
      @(posedge clk);
      if (cur < 0) begin
        if (m0_valid && m1_valid) cur = 1 - last;
        else if (m0_valid) cur = 0;
        else if (m1_valid) cur = 1;
        wd = 0;
      end else if (e_r0 || e_r1) begin
        last = cur;
        cur = -1;
        err = err | ex;
      end else if (!mv) begin
        cur = -1;
      end else begin
        wd++;
      end
      r0 = e_r0;
      r1 = e_r1;
      #1;
    end
    idle_inputs();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", pass_cnt, total);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write_passthrough();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
